// File: rtl/ov_stream_pkg.sv
// Shared definitions for the OV7670-style stream path: FSM states and the
// RGB332 <-> two-byte mapping used by both this transmitter and the capture block.
package ov_stream_pkg;

    localparam int ADDR_W = 15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_LINE   = 3'd3,
        S_HBLANK = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // byte0 carries R in [6:4] and the top of G in [1:0]; unused bits are 0.
    function automatic logic [7:0] pack_byte0(input logic [7:0] p);
        pack_byte0 = {1'b0, p[7:5], 2'b00, p[4:3]};
    endfunction

    // byte1 carries the low bit of G in [7] and B in [4:3].
    function automatic logic [7:0] pack_byte1(input logic [7:0] p);
        pack_byte1 = {p[2], 2'b00, p[1:0], 3'b000};
    endfunction

    function automatic logic [7:0] unpack_pixel(input logic [7:0] b0, input logic [7:0] b1);
        unpack_pixel = {b0[6:4], b0[1:0], b1[7], b1[4:3]};
    endfunction

endpackage

// File: rtl/ov_stream_tx_if.sv
// Frame-buffer read port plus the outgoing parallel video stream.
interface ov_stream_tx_if;
    import ov_stream_pkg::*;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              Vsync;
    logic              Href;
    logic [7:0]        D;

    modport master (
        output rd_en, rd_addr, Vsync, Href, D,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, Vsync, Href, D,
        output rd_data
    );

endinterface

// File: rtl/ov_stream_timing.sv
// Frame/line sequencer: FSM, phase/column/line counters, read strobe and
// address generation, and load strobes that tell the top which byte to drive.
module ov_stream_timing
    import ov_stream_pkg::*;
#(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int VS_CYC  = 8,
    parameter int VBP_CYC = 4,
    parameter int HB_CYC  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_vsync,
    output logic              o_href,
    output logic              o_ld0,
    output logic              o_ld1,
    output logic              o_frame_done,
    output logic              o_busy
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int LW     = $clog2(HEIGHT + 1);
    localparam int CW     = $clog2(2 * WIDTH);
    localparam int PH_MAX = (VS_CYC > VBP_CYC) ? ((VS_CYC > HB_CYC) ? VS_CYC : HB_CYC)
                                               : ((VBP_CYC > HB_CYC) ? VBP_CYC : HB_CYC);
    localparam int PW     = $clog2(PH_MAX + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(2 * WIDTH - 1);
    localparam logic [CW-1:0]     RD_COL_LIM = CW'(2 * WIDTH - 2);

    state_t            r_state;
    state_t            w_next;
    logic [PW-1:0]     r_cnt;
    logic [CW-1:0]     r_col;
    logic [LW-1:0]     r_line;
    logic [ADDR_W-1:0] r_addr;
    logic              r_vsync;
    logic              r_href;
    logic              w_rd_en;
    logic              w_more;

    assign w_more = (r_line < LW'(HEIGHT));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (i_enable) w_next = S_VSYNC;
            S_VSYNC:  if (r_cnt == PW'(VS_CYC - 1)) w_next = S_VBP;
            S_VBP:    if (r_cnt == PW'(VBP_CYC - 1)) w_next = S_LINE;
            S_LINE:   if (r_col == LAST_COL) w_next = S_HBLANK;
            S_HBLANK: if (r_cnt == PW'(HB_CYC - 1)) w_next = w_more ? S_LINE : S_DONE;
            S_DONE:   w_next = i_enable ? S_VSYNC : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Pixel k>0 is fetched on even line cycle 2k-2; pixel 0 two cycles before the line.
    always_comb begin
        w_rd_en = 1'b0;
        unique case (r_state)
            S_VBP:    w_rd_en = (r_cnt == PW'(VBP_CYC - 2));
            S_LINE:   w_rd_en = !r_col[0] && (r_col < RD_COL_LIM);
            S_HBLANK: w_rd_en = w_more && (r_cnt == PW'(HB_CYC - 2));
            default:  w_rd_en = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_col   <= '0;
            r_line  <= '0;
            r_addr  <= '0;
            r_vsync <= 1'b0;
            r_href  <= 1'b0;
        end else begin
            if ((w_next != r_state) || (r_state inside {S_IDLE, S_LINE}))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + PW'(1);

            if ((r_state == S_LINE) && (w_next == S_LINE))
                r_col <= r_col + CW'(1);
            else
                r_col <= '0;

            if (r_state == S_VSYNC)
                r_line <= '0;
            else if ((r_state == S_LINE) && (w_next == S_HBLANK))
                r_line <= r_line + LW'(1);

            // Address parks at the last pixel after the final read, then clears on DONE.
            if ((r_state == S_VSYNC) || (r_state == S_DONE))
                r_addr <= '0;
            else if (w_rd_en && (r_addr != LAST_ADDR))
                r_addr <= r_addr + ADDR_W'(1);

            r_vsync <= (w_next == S_VSYNC);
            r_href  <= (w_next == S_LINE);
        end
    end

    assign o_rd_en      = w_rd_en;
    assign o_rd_addr    = r_addr;
    assign o_vsync      = r_vsync;
    assign o_href       = r_href;
    assign o_ld0        = (w_next == S_LINE) && ((r_state != S_LINE) || r_col[0]);
    assign o_ld1        = (w_next == S_LINE) && (r_state == S_LINE) && !r_col[0];
    assign o_frame_done = (r_state == S_DONE);
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: rtl/ov_stream_tx.sv
// Frame-buffer to OV7670-style stream replayer: timing sequencer plus the
// pixel hold register and two-byte RGB332 packing onto D.
module ov_stream_tx
    import ov_stream_pkg::*;
#(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int VS_CYC  = 8,
    parameter int VBP_CYC = 4,
    parameter int HB_CYC  = 4
) (
    input  logic            Pclk,
    input  logic            rst,
    input  logic            enable,
    ov_stream_tx_if.master  bus,
    output logic            frame_done,
    output logic            busy
);

    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_vsync;
    logic              w_href;
    logic              w_ld0;
    logic              w_ld1;
    logic [7:0]        r_hold;
    logic [7:0]        r_d;

    ov_stream_timing #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .VS_CYC  (VS_CYC),
        .VBP_CYC (VBP_CYC),
        .HB_CYC  (HB_CYC)
    ) u_timing (
        .i_clk        (Pclk),
        .i_rst        (rst),
        .i_enable     (enable),
        .o_rd_en      (w_rd_en),
        .o_rd_addr    (w_rd_addr),
        .o_vsync      (w_vsync),
        .o_href       (w_href),
        .o_ld0        (w_ld0),
        .o_ld1        (w_ld1),
        .o_frame_done (frame_done),
        .o_busy       (busy)
    );

    // rd_data is only guaranteed on its valid cycle, so byte1 comes from the held copy.
    always_ff @(posedge Pclk) begin
        if (w_ld0) r_hold <= bus.rd_data;
    end

    always_ff @(posedge Pclk or posedge rst) begin
        if (rst)        r_d <= '0;
        else if (w_ld0) r_d <= pack_byte0(bus.rd_data);
        else if (w_ld1) r_d <= pack_byte1(r_hold);
        else            r_d <= '0;
    end

    assign bus.rd_en   = w_rd_en;
    assign bus.rd_addr = w_rd_addr;
    assign bus.Vsync   = w_vsync;
    assign bus.Href    = w_href;
    assign bus.D       = r_d;

endmodule

// File: tb/tb_ov_stream_tx.sv
// Directed bench: small 4x2 frame for geometry/packing/reads/reset/enable,
// full 160x120 instance looped back through a capture model.
module tb_ov_stream_tx;
    import ov_stream_pkg::*;

    logic clk = 1'b0;
    logic rst_s, en_s, rst_b, en_b;
    logic fd_s, busy_s, fd_b, busy_b;
    int   checks = 0;
    int   errors = 0;

    ov_stream_tx_if bus_s ();
    ov_stream_tx_if bus_b ();

    ov_stream_tx #(.WIDTH(4), .HEIGHT(2), .VS_CYC(3), .VBP_CYC(2), .HB_CYC(2)) u_small (
        .Pclk(clk), .rst(rst_s), .enable(en_s), .bus(bus_s),
        .frame_done(fd_s), .busy(busy_s));

    ov_stream_tx u_big (
        .Pclk(clk), .rst(rst_b), .enable(en_b), .bus(bus_b),
        .frame_done(fd_b), .busy(busy_b));

    initial forever #5 clk = ~clk;

    logic [7:0] mem_s [0:7];
    logic [7:0] mem_b [0:19199];
    logic [7:0] cap_b [0:19199];

    // Frame buffers: data valid the cycle after rd_en, noise otherwise.
    always @(posedge clk) begin
        bus_s.rd_data <= bus_s.rd_en ? mem_s[bus_s.rd_addr[2:0]] : 8'($urandom);
        bus_b.rd_data <= bus_b.rd_en ? mem_b[int'(bus_b.rd_addr) % 19200] : 8'($urandom);
    end

    int         cap_idx = 0;
    logic       cap_phase = 1'b0;
    logic [7:0] cap_b0;
    always @(negedge clk) begin
        if (bus_b.Vsync) begin
            cap_idx   = 0;
            cap_phase = 1'b0;
        end else if (bus_b.Href) begin
            if (!cap_phase) begin
                cap_b0    = bus_b.D;
                cap_phase = 1'b1;
            end else begin
                if (cap_idx < 19200) cap_b[cap_idx] = unpack_pixel(cap_b0, bus_b.D);
                cap_idx++;
                cap_phase = 1'b0;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] e0(input logic [7:0] p);
        e0 = 8'((((p >> 5) & 8'd7) << 4) | ((p >> 3) & 8'd3));
    endfunction

    function automatic logic [7:0] e1(input logic [7:0] p);
        e1 = 8'((((p >> 2) & 8'd1) << 7) | ((p & 8'd3) << 3));
    endfunction

    logic        vs_a [0:34];
    logic        hr_a [0:34];
    logic        fd_a [0:34];
    logic        re_a [0:34];
    logic [7:0]  d_a  [0:34];
    logic [14:0] ad_a [0:34];

    initial begin
        int n, nbad, nrd, nvs, nhr, nfd, nrv;
        logic found;
        logic [7:0] px;

        mem_s[0] = 8'hFF; mem_s[1] = 8'hA5; mem_s[2] = 8'h3C; mem_s[3] = 8'h81;
        mem_s[4] = 8'h12; mem_s[5] = 8'hE7; mem_s[6] = 8'h5A; mem_s[7] = 8'h06;
        for (int i = 0; i < 19200; i++) mem_b[i] = 8'(i);

        rst_s = 1'b1; en_s = 1'b0; rst_b = 1'b1; en_b = 1'b0;
        repeat (3) tick;
        chk("rst_vsync", bus_s.Vsync, 0);
        chk("rst_href", bus_s.Href, 0);
        chk("rst_d", bus_s.D, 0);
        chk("rst_rd_en", bus_s.rd_en, 0);
        chk("rst_rd_addr", bus_s.rd_addr, 0);
        chk("rst_frame_done", fd_s, 0);
        chk("rst_busy", busy_s, 0);

        rst_s = 1'b0;
        repeat (2) tick;
        chk("idle_busy", busy_s, 0);

        // One full frame plus the start of the next, cycle 0 = first cycle after leaving IDLE.
        en_s = 1'b1;
        for (int c = 0; c < 35; c++) begin
            tick;
            vs_a[c] = bus_s.Vsync; hr_a[c] = bus_s.Href; fd_a[c] = fd_s;
            re_a[c] = bus_s.rd_en; d_a[c] = bus_s.D; ad_a[c] = bus_s.rd_addr;
        end

        nvs = 0; nhr = 0; nfd = 0; nrd = 0; nrv = 0; nbad = 0;
        for (int c = 0; c < 26; c++) begin
            logic exp_hr;
            exp_hr = ((c >= 5) && (c <= 12)) || ((c >= 15) && (c <= 22));
            if (vs_a[c]) nvs++;
            if (hr_a[c]) nhr++;
            if (fd_a[c]) nfd++;
            if (hr_a[c] !== exp_hr) nbad++;
            if (re_a[c]) begin
                if (ad_a[c] !== 15'(nrd)) nbad++;
                if (vs_a[c]) nrv++;
                nrd++;
            end
        end
        chk("vsync_first_cycle", vs_a[0], 1);
        chk("vsync_len", nvs, 3);
        chk("href_len", nhr, 16);
        chk("first_href_latency", {hr_a[4], hr_a[5]}, 2'b01);
        chk("href_addr_pattern_bad", nbad, 0);
        chk("frame_done_count", nfd, 1);
        chk("frame_done_cycle25", fd_a[25], 1);
        chk("rd_en_count", nrd, 8);
        chk("rd_en_during_vsync", nrv, 0);

        chk("pack_ff_b0", d_a[5], 8'h73);
        chk("pack_ff_b1", d_a[6], 8'h98);
        chk("pack_a5_b0", d_a[7], 8'h50);
        chk("pack_a5_b1", d_a[8], 8'h88);
        nbad = 0;
        for (int l = 0; l < 2; l++)
            for (int k = 0; k < 4; k++) begin
                px = mem_s[l * 4 + k];
                if (d_a[5 + 10 * l + 2 * k] !== e0(px)) nbad++;
                if (d_a[6 + 10 * l + 2 * k] !== e1(px)) nbad++;
            end
        for (int c = 0; c < 26; c++) if (!hr_a[c] && (d_a[c] !== 8'h00)) nbad++;
        chk("d_stream_bad", nbad, 0);
        chk("next_frame_vsync", vs_a[26], 1);
        chk("next_frame_addr", ad_a[26], 0);

        // Cycle 34 is mid-LINE of the second frame; reset must clear outputs at once.
        chk("pre_reset_href", bus_s.Href, 1);
        rst_s = 1'b1;
        #1;
        chk("async_rst_href", bus_s.Href, 0);
        chk("async_rst_d", bus_s.D, 0);
        chk("async_rst_rd_addr", bus_s.rd_addr, 0);
        chk("async_rst_busy", busy_s, 0);
        tick;
        rst_s = 1'b0;
        tick;
        chk("post_rst_vsync", bus_s.Vsync, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick;
            if (bus_s.rd_en) begin
                found = 1'b1;
                chk("post_rst_first_addr", bus_s.rd_addr, 0);
            end
        end
        chk("post_rst_read_seen", found, 1);

        // Drop enable once the line starts; the frame must still finish.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick;
            found = bus_s.Href;
        end
        chk("href_reached", found, 1);
        en_s = 1'b0;
        nhr = 1; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick;
            if (bus_s.Href) nhr++;
            found = fd_s;
        end
        chk("drop_frame_done", found, 1);
        chk("drop_href_total", nhr, 16);
        tick;
        chk("drop_busy_low", busy_s, 0);
        chk("drop_vsync_low", bus_s.Vsync, 0);
        chk("drop_addr_low", bus_s.rd_addr, 0);
        repeat (3) tick;
        chk("idle_stays", busy_s, 0);

        // Full-size loopback.
        rst_b = 1'b0;
        en_b  = 1'b1;
        tick;
        chk("big_vsync_start", bus_b.Vsync, 1);
        en_b = 1'b0;
        n = 0; found = 1'b0;
        while (!found && n < 40000) begin
            tick;
            n++;
            found = fd_b;
        end
        chk("big_frame_done", found, 1);
        chk("big_frame_len", n, 8 + 4 + 120 * (2 * 160 + 4));
        tick;
        chk("big_busy_low", busy_b, 0);
        chk("big_captured_count", cap_idx, 19200);
        nbad = 0;
        for (int i = 0; i < 19200; i++) if (cap_b[i] !== mem_b[i]) nbad++;
        chk("loopback_bad", nbad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
